// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// State encodings, instruction classes, opcodes, ALU op codes, ALU bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_ALU     = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_ILLEGAL = 3'd4
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Register-operand ops
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    // Immediate-operand ops use their own numbering
    localparam logic [3:0] ALUI_ADDI = 4'b0000;
    localparam logic [3:0] ALUI_XORI = 4'b0001;
    localparam logic [3:0] ALUI_ORI  = 4'b0010;
    localparam logic [3:0] ALUI_ANDI = 4'b0011;
    localparam logic [3:0] ALUI_SLLI = 4'b0100;
    localparam logic [3:0] ALUI_SRAI = 4'b0101;
    localparam logic [3:0] ALUI_SRLI = 4'b0110;

    // br = {beq, bne, blt, bge, bltu, bgeu}
    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       sftmd;
        logic [5:0] br;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: instr -> ALU bundle, class, illegal.
// Ports: instr (in 32), ctrl (out alu_ctrl_t), iclass (out), illegal (out).
module alu_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output alu_ctrl_t   ctrl,
    output iclass_t     iclass,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are consumed by the datapath
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl   = '0;
        iclass = C_ILLEGAL;
        case (opcode)
            OP_R: begin
                iclass = C_ALU;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: ctrl.aluop = ALU_ADD;
                        3'b001: begin
                            ctrl.aluop = ALU_SLL;
                            ctrl.sftmd = 1'b1;
                        end
                        3'b100: ctrl.aluop = ALU_XOR;
                        3'b101: begin
                            ctrl.aluop = ALU_SRL;
                            ctrl.sftmd = 1'b1;
                        end
                        3'b110: ctrl.aluop = ALU_OR;
                        3'b111: ctrl.aluop = ALU_AND;
                        default: iclass = C_ILLEGAL;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000: ctrl.aluop = ALU_SUB;
                        3'b101: begin
                            ctrl.aluop = ALU_SRA;
                            ctrl.sftmd = 1'b1;
                        end
                        default: iclass = C_ILLEGAL;
                    endcase
                end else begin
                    iclass = C_ILLEGAL;
                end
            end
            OP_I_ALU: begin
                iclass      = C_ALU;
                ctrl.alusrc = 1'b1;
                case (funct3)
                    3'b000: ctrl.aluop = ALUI_ADDI;
                    3'b100: ctrl.aluop = ALUI_XORI;
                    3'b110: ctrl.aluop = ALUI_ORI;
                    3'b111: ctrl.aluop = ALUI_ANDI;
                    3'b001: begin
                        ctrl.aluop = ALUI_SLLI;
                        ctrl.sftmd = 1'b1;
                    end
                    3'b101: begin
                        // instr[30] separates srai from srli
                        ctrl.aluop = instr[30] ? ALUI_SRAI : ALUI_SRLI;
                        ctrl.sftmd = 1'b1;
                    end
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_LOAD: begin
                iclass      = C_LOAD;
                ctrl.alusrc = 1'b1;
            end
            OP_STORE: begin
                iclass      = C_STORE;
                ctrl.alusrc = 1'b1;
            end
            OP_BRANCH: begin
                iclass = C_BRANCH;
                case (funct3)
                    3'b000: ctrl.br = 6'b100000;
                    3'b001: ctrl.br = 6'b010000;
                    3'b100: ctrl.br = 6'b001000;
                    3'b101: ctrl.br = 6'b000100;
                    3'b110: ctrl.br = 6'b000010;
                    3'b111: ctrl.br = 6'b000001;
                    default: iclass = C_ILLEGAL;
                endcase
            end
            default: iclass = C_ILLEGAL;
        endcase
        // An illegal instruction never carries a partial bundle
        if (iclass == C_ILLEGAL) begin
            ctrl = '0;
        end
    end

    assign illegal = (iclass == C_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP.
// Ports: clk, rst, instr, branch_result, dmem_ready in; ALU bundle, enables, illegal, state out.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit RESET_ILLEGAL_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_result,
    input  logic        dmem_ready,
    output logic [3:0]  ALUop,
    output logic        ALUSrc,
    output logic        sftmd,
    output logic        Branch,
    output logic        nBranch,
    output logic        Branch_lt,
    output logic        Branch_ge,
    output logic        Branch_ltu,
    output logic        Branch_geu,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t    state_q;
    state_t    state_d;
    alu_ctrl_t dec_ctrl;
    iclass_t   dec_class;
    logic      dec_illegal;
    alu_ctrl_t alu;

    alu_decode u_dec (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .iclass  (dec_class),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu        = '0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        illegal    = 1'b0;
        // Outputs are forced low for the whole reset pulse, so an
        // asynchronous reset drops a pending dmem_req immediately.
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
                S_DECODE: begin
                    state_d = dec_illegal ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    alu = dec_ctrl;
                    case (dec_class)
                        C_ALU:   state_d = S_WB;
                        C_LOAD:  state_d = S_MEM;
                        C_STORE: state_d = S_MEM;
                        C_BRANCH: begin
                            pc_write = 1'b1;
                            pc_src   = branch_result;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    alu      = dec_ctrl;
                    dmem_req = 1'b1;
                    dmem_we  = (dec_class == C_STORE);
                    if (dmem_ready) begin
                        if (dec_class == C_STORE) begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    mem_to_reg = (dec_class == C_LOAD);
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    if (!RESET_ILLEGAL_STICKY) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign ALUop      = alu.aluop;
    assign ALUSrc     = alu.alusrc;
    assign sftmd      = alu.sftmd;
    assign Branch     = alu.br[5];
    assign nBranch    = alu.br[4];
    assign Branch_lt  = alu.br[3];
    assign Branch_ge  = alu.br[2];
    assign Branch_ltu = alu.br[1];
    assign Branch_geu = alu.br[0];
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Each task drives one scenario and compares against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        branch_result = 1'b0;
    logic        dmem_ready = 1'b0;
    logic [3:0]  ALUop;
    logic        ALUSrc, sftmd;
    logic        Branch, nBranch, Branch_lt, Branch_ge;
    logic        Branch_ltu, Branch_geu;
    logic        pc_write, pc_src, ir_write, reg_write;
    logic        mem_to_reg, dmem_req, dmem_we, illegal;
    logic [2:0]  state;

    int checks = 0;
    int passes = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .branch_result (branch_result),
        .dmem_ready    (dmem_ready),
        .ALUop         (ALUop),
        .ALUSrc        (ALUSrc),
        .sftmd         (sftmd),
        .Branch        (Branch),
        .nBranch       (nBranch),
        .Branch_lt     (Branch_lt),
        .Branch_ge     (Branch_ge),
        .Branch_ltu    (Branch_ltu),
        .Branch_geu    (Branch_geu),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_src, ir_write, reg_write, mem_to_reg, dmem_req, dmem_we}
    wire [6:0]  en  = {pc_write, pc_src, ir_write, reg_write,
                       mem_to_reg, dmem_req, dmem_we};
    // {ALUop, ALUSrc, sftmd, beq, bne, blt, bge, bltu, bgeu}
    wire [11:0] bun = {ALUop, ALUSrc, sftmd, Branch, nBranch,
                       Branch_lt, Branch_ge, Branch_ltu, Branch_geu};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (state !== 3'd0 || en !== 7'h0 || bun !== 12'h0 || illegal !== 1'b0)
            $display("FAIL reset_outputs: state=%0d en=%b bun=%h ill=%b, need 0/0/0/0",
                     state, en, bun, illegal);
        else passes++;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || en !== 7'b0010000)
            $display("FAIL reset_release: state=%0d en=%b, need 0 0010000", state, en);
        else passes++;
    endtask

    task automatic test_add;
        instr = 32'h002081B3;
        step();
        checks++;
        if (state !== 3'd1 || en !== 7'h0)
            $display("FAIL add_decode: state=%0d en=%b, need 1 0000000", state, en);
        else passes++;
        step();
        checks++;
        if (state !== 3'd2 || bun !== 12'h000 || en !== 7'h0)
            $display("FAIL add_exec: state=%0d bun=%h en=%b, need 2 000 0000000",
                     state, bun, en);
        else passes++;
        step();
        checks++;
        if (state !== 3'd4 || en !== 7'b1001000 || bun !== 12'h0)
            $display("FAIL add_wb: state=%0d en=%b bun=%h, need 4 1001000 000",
                     state, en, bun);
        else passes++;
        step();
        checks++;
        if (state !== 3'd0)
            $display("FAIL add_done: state=%0d, need 0", state);
        else passes++;
    endtask

    task automatic test_alu_decode;
        logic [31:0] ins [0:6];
        logic [11:0] exp [0:6];
        int rw;
        ins = '{32'h4032D293, 32'h40208133, 32'h4020D133, 32'h0040C093,
                32'h002091B3, 32'h0032D293, 32'h0020F1B3};
        exp = '{12'h5C0, 12'h100, 12'h740, 12'h180,
                12'h540, 12'h6C0, 12'h400};
        for (int i = 0; i < 7; i++) begin
            instr = ins[i];
            rw = 0;
            step();
            step();
            checks++;
            if (state !== 3'd2 || bun !== exp[i])
                $display("FAIL alu_exec[%0d]: state=%0d bun=%h, need 2 %h",
                         i, state, bun, exp[i]);
            else passes++;
            if (reg_write) rw++;
            step();
            if (reg_write) rw++;
            step();
            if (reg_write) rw++;
            checks++;
            if (rw != 1 || state !== 3'd0)
                $display("FAIL alu_wb[%0d]: reg_write=%0d state=%0d, need 1 0",
                         i, rw, state);
            else passes++;
        end
    endtask

    task automatic test_load;
        int cyc, req, mseen, wbad;
        logic [6:0]  wb_en;
        logic [11:0] ex_bun;
        instr = 32'h0080A203;
        dmem_ready = 1'b0;
        cyc = 0; req = 0; mseen = 0; wbad = 0;
        wb_en = 7'h0; ex_bun = 12'hFFF;
        do begin
            cyc++;
            if (dmem_req) req++;
            if (dmem_req && dmem_we) wbad++;
            if (state == 3'd2) ex_bun = bun;
            if (state == 3'd4) wb_en = en;
            if (state == 3'd3) begin
                mseen++;
                dmem_ready = (mseen == 3);
            end else begin
                dmem_ready = 1'b0;
            end
            step();
        end while (state != 3'd0 && cyc < 20);
        dmem_ready = 1'b0;
        checks++;
        if (cyc != 7)
            $display("FAIL load_latency: cycles=%0d, need 7", cyc);
        else passes++;
        checks++;
        if (req != 3 || wbad != 0)
            $display("FAIL load_req: req_cycles=%0d we_high=%0d, need 3 0", req, wbad);
        else passes++;
        checks++;
        if (wb_en !== 7'b1001100 || ex_bun !== 12'h080)
            $display("FAIL load_wb: wb_en=%b exec_bun=%h, need 1001100 080",
                     wb_en, ex_bun);
        else passes++;
    endtask

    task automatic test_store;
        int cyc, rw;
        logic [6:0] mem_en;
        instr = 32'h0020A223;
        dmem_ready = 1'b1;
        cyc = 0; rw = 0; mem_en = 7'h0;
        do begin
            cyc++;
            if (reg_write) rw++;
            if (state == 3'd3) mem_en = en;
            step();
        end while (state != 3'd0 && cyc < 20);
        dmem_ready = 1'b0;
        checks++;
        if (cyc != 4 || rw != 0)
            $display("FAIL store_latency: cycles=%0d reg_write=%0d, need 4 0", cyc, rw);
        else passes++;
        checks++;
        if (mem_en !== 7'b1000011)
            $display("FAIL store_mem: en=%b, need 1000011", mem_en);
        else passes++;
    endtask

    task automatic test_branch;
        logic [31:0] ins [0:2];
        logic        br  [0:2];
        logic [11:0] eb  [0:2];
        logic [6:0]  ee  [0:2];
        ins = '{32'h0020E463, 32'h00000063, 32'h00001063};
        br  = '{1'b1, 1'b0, 1'b1};
        eb  = '{12'h002, 12'h020, 12'h010};
        ee  = '{7'b1100000, 7'b1000000, 7'b1100000};
        for (int i = 0; i < 3; i++) begin
            instr = ins[i];
            branch_result = br[i];
            step();
            step();
            checks++;
            if (state !== 3'd2 || bun !== eb[i] || en !== ee[i])
                $display("FAIL branch_exec[%0d]: state=%0d bun=%h en=%b, need 2 %h %b",
                         i, state, bun, en, eb[i], ee[i]);
            else passes++;
            step();
            checks++;
            if (state !== 3'd0)
                $display("FAIL branch_done[%0d]: state=%0d, need 0", i, state);
            else passes++;
        end
        branch_result = 1'b0;
    endtask

    task automatic test_illegal;
        logic [31:0] ins [0:5];
        ins = '{32'h0020A1B3, 32'h00002063, 32'h022081B3,
                32'h40209133, 32'h0020A093, 32'h00000037};
        for (int i = 0; i < 6; i++) begin
            instr = ins[i];
            step();
            checks++;
            if (state !== 3'd1 || illegal !== 1'b0)
                $display("FAIL illegal_decode[%0d]: state=%0d ill=%b, need 1 0",
                         i, state, illegal);
            else passes++;
            step();
            checks++;
            if (state !== 3'd5 || illegal !== 1'b1 || en !== 7'h0 || bun !== 12'h0)
                $display("FAIL illegal_trap[%0d]: state=%0d ill=%b en=%b bun=%h, need 5 1 0 0",
                         i, state, illegal, en, bun);
            else passes++;
            do_reset();
        end
    endtask

    task automatic test_trap_sticky;
        int bad;
        instr = 32'h00000000;
        step();
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (state !== 3'd5 || illegal !== 1'b1 || en !== 7'h0) bad++;
            step();
        end
        checks++;
        if (bad != 0)
            $display("FAIL trap_sticky: bad_cycles=%0d, need 0", bad);
        else passes++;
        do_reset();
        checks++;
        if (state !== 3'd0 || illegal !== 1'b0)
            $display("FAIL trap_exit: state=%0d ill=%b, need 0 0", state, illegal);
        else passes++;
    endtask

    task automatic test_reset_in_mem;
        instr = 32'h0080A203;
        dmem_ready = 1'b0;
        step();
        step();
        step();
        checks++;
        if (state !== 3'd3 || dmem_req !== 1'b1)
            $display("FAIL rst_mem_pre: state=%0d req=%b, need 3 1", state, dmem_req);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || dmem_req !== 1'b0)
            $display("FAIL rst_mem_async: state=%0d req=%b, need 0 0", state, dmem_req);
        else passes++;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_decode();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_trap_sticky();
        test_reset_in_mem();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
